// File: rtl/merge_pkg.sv
// Shared constants and width helpers for the N-way merge arbiter.
package merge_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Source-index width: at least one bit even for a 2-way merge.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Occupancy counter must represent DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/arb_rr_n.sv
// N-way request arbiter: fixed priority or round-robin with a registered pointer.
module arb_rr_n
  import merge_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int MODE  = MODE_RR,
  localparam int SEL_W = sel_width(N_IN)
) (
  input  logic             CLK,
  input  logic             MR_N,
  input  logic [N_IN-1:0]  i_req,
  input  logic             i_xfer,
  output logic [N_IN-1:0]  o_grant,
  output logic [SEL_W-1:0] o_grant_idx
);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_idx_k;
  logic             w_found;

  // Search starts at r_ptr and wraps; in fixed mode r_ptr never leaves 0.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx_k     = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_idx_k = SEL_W'((int'(r_ptr) + k) % N_IN);
      if (!w_found && i_req[w_idx_k]) begin
        w_found          = 1'b1;
        o_grant[w_idx_k] = 1'b1;
        o_grant_idx      = w_idx_k;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!MR_N) begin
      r_ptr <= '0;
    end else if (MODE == MODE_RR && i_xfer) begin
      r_ptr <= SEL_W'((int'(o_grant_idx) + 1) % N_IN);
    end
  end

endmodule

// File: rtl/merge_arb_n.sv
// Merges N_IN valid/ack channels into one FIFO-buffered output stream,
// tagging each item with its source channel index.
module merge_arb_n
  import merge_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int DW    = 8,
  parameter  int DEPTH = 4,
  parameter  int MODE  = MODE_RR,
  localparam int SEL_W = sel_width(N_IN),
  localparam int CW    = cnt_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               MR_N,
  input  logic [N_IN-1:0]    Send_in,
  input  logic [N_IN*DW-1:0] Data_in,
  output logic [N_IN-1:0]    Ack_out,
  output logic               Send_out,
  output logic [DW-1:0]      Data_out,
  output logic [SEL_W-1:0]   Sel_out,
  input  logic               Ack_in,
  output logic [CW-1:0]      Count
);

  logic [DW-1:0]    r_mem_data [DEPTH];
  logic [SEL_W-1:0] r_mem_sel  [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic [N_IN-1:0]  w_grant;
  logic [SEL_W-1:0] w_grant_idx;
  logic [DW-1:0]    w_ch_data [N_IN];
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_slice
      assign w_ch_data[gi] = Data_in[gi*DW +: DW];
    end
  endgenerate

  arb_rr_n #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_arb (
    .CLK         (CLK),
    .MR_N        (MR_N),
    .i_req       (Send_in),
    .i_xfer      (w_push),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Full blocks acceptance outright, even if the head is popped this cycle.
  assign w_full  = (r_count == CW'(DEPTH));
  assign Ack_out = w_grant & {N_IN{~w_full & MR_N}};
  assign w_push  = |(Send_in & Ack_out);
  assign w_pop   = (r_count != '0) & Ack_in;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_ch_data[w_grant_idx];
      r_mem_sel[r_wr_ptr]  <= w_grant_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (!MR_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head is forced to zero when empty so reset leaves clean outputs.
  assign Count    = r_count;
  assign Send_out = (r_count != '0);
  assign Data_out = Send_out ? r_mem_data[r_rd_ptr] : '0;
  assign Sel_out  = Send_out ? r_mem_sel[r_rd_ptr]  : '0;

endmodule
